// File: rtl/ram8_master.sv
// ----------------------------------------------------------------------------
// ram8_master
//
// Burst master for a small single-port RAM with a combinational read port.
// A command (start address + word count) is taken on a valid/ready handshake.
// It then either streams write data from wr_* into the RAM, or streams RAM
// words out on rd_* through a one-entry output register. The address walks
// upward modulo 2**ADDR_W, so a burst that runs past the top address wraps
// to address 0.
//
// Parameters
//   DATA_W  word width
//   ADDR_W  RAM address width (2**ADDR_W words)
//
// Ports
//   clk, rst_n                       clock, asynchronous active-low reset
//   cmd_valid/cmd_ready              command handshake
//   cmd_write                        1 = burst write, 0 = burst read
//   cmd_addr                         first address of the burst
//   cmd_len                          number of words minus one
//   wr_valid/wr_ready/wr_data        write-data stream (sink)
//   rd_valid/rd_ready/rd_data        read-data stream (source)
//   ram_addr/ram_in/ram_load         RAM address, write data, write enable
//   ram_out                          RAM read data for ram_addr
//   busy                             high whenever not IDLE
//   done                             one-cycle pulse at burst completion
// ----------------------------------------------------------------------------
module ram8_master #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_in,
  output logic              ram_load,
  input  logic [DATA_W-1:0] ram_out,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] remaining;
  // In READ: at least one word still has to be fetched from the RAM.
  // remaining alone cannot express "zero left to fetch" because it counts
  // words minus one, so this flag marks the end of the fetch phase.
  logic              pending;
  logic              fetch;

  // Address increment; the natural ADDR_W-bit overflow gives the wrap.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return ADDR_W'(a + 1'b1);
  endfunction

  // Outputs decoded from registered state. Because state and cur_addr are
  // cleared asynchronously, every one of these drops to its idle value the
  // moment rst_n falls, without waiting for a clock edge.
  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign wr_ready  = (state == S_WRITE);
  assign ram_load  = (state == S_WRITE) && wr_valid;
  assign ram_in    = (state == S_WRITE) ? wr_data : '0;
  assign ram_addr  = cur_addr;

  // The output register may be refilled when it is empty or its word is
  // being taken on this same edge, which gives one word per cycle under
  // continuous rd_ready.
  assign fetch = (state == S_READ) && pending && (!rd_valid || rd_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cur_addr  <= '0;
      remaining <= '0;
      pending   <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            cur_addr  <= cmd_addr;
            remaining <= cmd_len;
            pending   <= !cmd_write;
            state     <= cmd_write ? S_WRITE : S_READ;
          end
        end

        S_WRITE: begin
          // The RAM captures ram_in on this same edge; a low wr_valid
          // leaves both address and count untouched.
          if (wr_valid) begin
            cur_addr <= next_addr(cur_addr);
            if (remaining == '0) begin
              state <= S_DONE;
            end else begin
              remaining <= remaining - 1'b1;
            end
          end
        end

        S_READ: begin
          if (fetch) begin
            rd_data  <= ram_out;
            rd_valid <= 1'b1;
            cur_addr <= next_addr(cur_addr);
            if (remaining == '0) begin
              pending <= 1'b0;
            end else begin
              remaining <= remaining - 1'b1;
            end
          end else if (rd_valid && rd_ready) begin
            // No fetch while the consumer is ready means nothing is left to
            // fetch, so this was the final word of the burst.
            rd_valid <= 1'b0;
            state    <= S_DONE;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram8_master.sv
// ----------------------------------------------------------------------------
// tb_ram8_master
//
// Drives ram8_master against a behavioural 8-word RAM and checks it against a
// reference image of the memory: every write burst updates ref_mem by plain
// modulo-8 arithmetic, and every read burst must return ref_mem contents in
// order. Directed bursts cover write/read, wrap, backpressure, write stall,
// reset mid-burst and a command held during a burst; a randomized loop follows.
// ----------------------------------------------------------------------------
module tb_ram8_master;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_write = 1'b0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [ADDR_W-1:0] cmd_len = '0;
  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data = '0;
  logic              rd_valid;
  logic              rd_ready = 1'b0;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_in;
  logic              ram_load;
  logic [DATA_W-1:0] ram_out;
  logic              busy;
  logic              done;

  logic [DATA_W-1:0] mem     [DEPTH] = '{default: '0};
  logic [DATA_W-1:0] ref_mem [DEPTH] = '{default: '0};
  logic [DATA_W-1:0] wbuf    [DEPTH] = '{default: '0};

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ram8_master #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .ram_addr(ram_addr), .ram_in(ram_in), .ram_load(ram_load), .ram_out(ram_out),
    .busy(busy), .done(done)
  );

  // Behavioural RAM: synchronous write, combinational read.
  always @(posedge clk) begin
    if (ram_load) mem[ram_addr] <= ram_in;
  end
  assign ram_out = mem[ram_addr];

  function automatic logic [2:0] wrap(input int x);
    return 3'(x % DEPTH);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Offers a command and returns at the negedge one cycle after acceptance.
  task automatic send_cmd(input bit wr, input int a, input int l);
    int t = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = wrap(a);
    cmd_len   = wrap(l);
    #1;
    while (!cmd_ready && t < 50) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk("cmd_accept", 32'(cmd_ready), 1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Called at the negedge where the FSM should be in DONE.
  task automatic check_done();
    #1;
    chk("done_pulse", 32'(done), 1);
    chk("done_busy", 32'(busy), 1);
    chk("done_cmd_ready", 32'(cmd_ready), 0);
    chk("done_rd_valid", 32'(rd_valid), 0);
    chk("done_ram_load", 32'(ram_load), 0);
    @(negedge clk);
    #1;
    chk("idle_done", 32'(done), 0);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_cmd_ready", 32'(cmd_ready), 1);
  endtask

  // Drives len+1 beats from wbuf, optionally stalling before beat stall_at.
  task automatic write_body(input int a, input int l, input int stall_at, input int stall_n);
    for (int i = 0; i <= l; i++) begin
      if (i == stall_at) begin
        for (int s = 0; s < stall_n; s++) begin
          wr_valid = 1'b0;
          wr_data  = 8'($urandom);
          #1;
          chk("stall_ram_load", 32'(ram_load), 0);
          chk("stall_ram_addr", 32'(ram_addr), 32'(wrap(a + i)));
          chk("stall_wr_ready", 32'(wr_ready), 1);
          @(negedge clk);
        end
      end
      wr_valid = 1'b1;
      wr_data  = wbuf[i];
      #1;
      chk("wr_ready", 32'(wr_ready), 1);
      chk("ram_load", 32'(ram_load), 1);
      chk("ram_addr", 32'(ram_addr), 32'(wrap(a + i)));
      chk("ram_in", 32'(ram_in), 32'(wbuf[i]));
      chk("wr_cmd_hold_off", 32'(cmd_ready), 0);
      @(negedge clk);
    end
    wr_valid = 1'b0;
    for (int i = 0; i <= l; i++) ref_mem[wrap(a + i)] = wbuf[i];
    check_done();
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0,1, 2: random ready.
  task automatic read_body(input int a, input int l, input int mode);
    int k = 0;
    int cyc = 0;
    logic hold = 1'b0;
    logic [DATA_W-1:0] held = '0;
    #1;
    chk("rd_first_cycle_valid", 32'(rd_valid), 0);
    chk("rd_busy", 32'(busy), 1);
    while (k <= l && cyc < 200) begin
      case (mode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: rd_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (cyc == 1) chk("rd_latency", 32'(rd_valid), 1);
      if (hold) begin
        chk("rd_stall_valid", 32'(rd_valid), 1);
        chk("rd_stall_data", 32'(rd_data), 32'(held));
      end
      chk("rd_ram_load", 32'(ram_load), 0);
      if (rd_valid && rd_ready) begin
        chk("rd_data", 32'(rd_data), 32'(ref_mem[wrap(a + k)]));
        k++;
      end
      hold = rd_valid && !rd_ready;
      held = rd_data;
      cyc++;
      @(negedge clk);
    end
    if (k <= l) chk("rd_timeout_words", 32'(k), 32'(l + 1));
    rd_ready = 1'b0;
    check_done();
  endtask

  task automatic write_burst(input int a, input int l, input int stall_at, input int stall_n);
    send_cmd(1'b1, a, l);
    write_body(a, l, stall_at, stall_n);
  endtask

  task automatic read_burst(input int a, input int l, input int mode);
    send_cmd(1'b0, a, l);
    read_body(a, l, mode);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset, with wr_valid high so ram_load would show if not forced off.
    wr_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    chk("rst_ram_load", 32'(ram_load), 0);
    chk("rst_wr_ready", 32'(wr_ready), 0);
    chk("rst_ram_addr", 32'(ram_addr), 0);
    repeat (2) @(negedge clk);
    wr_valid = 1'b0;
    rst_n = 1'b1;
    #1 chk("post_rst_cmd_ready", 32'(cmd_ready), 1);

    // Write then read back at address 2.
    wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33; wbuf[3] = 8'h44;
    write_burst(2, 3, -1, 0);
    chk("ram_word2", 32'(mem[2]), 32'h11);
    chk("ram_word5", 32'(mem[5]), 32'h44);
    read_burst(2, 3, 0);

    // Wrap across the top address.
    wbuf[0] = 8'hA0; wbuf[1] = 8'hA1; wbuf[2] = 8'hA2; wbuf[3] = 8'hA3;
    write_burst(6, 3, -1, 0);
    chk("wrap_ram_word0", 32'(mem[0]), 32'hA2);
    read_burst(6, 3, 0);

    // Full 8-word fill, then backpressured 8-word read from a wrapped start.
    for (int i = 0; i < DEPTH; i++) wbuf[i] = 8'($urandom);
    write_burst(0, 7, -1, 0);
    read_burst(3, 7, 1);

    // Write with a 3-cycle wr_valid gap mid-burst.
    for (int i = 0; i < DEPTH; i++) wbuf[i] = 8'($urandom);
    write_burst(1, 4, 2, 3);
    read_burst(1, 4, 0);

    // Reset after 2 of 5 write beats.
    for (int i = 0; i < DEPTH; i++) wbuf[i] = 8'($urandom);
    send_cmd(1'b1, 4, 4);
    for (int i = 0; i < 2; i++) begin
      wr_valid = 1'b1;
      wr_data  = wbuf[i];
      @(negedge clk);
    end
    wr_data = wbuf[2];
    rst_n = 1'b0;
    #1;
    chk("midrst_ram_load", 32'(ram_load), 0);
    chk("midrst_wr_ready", 32'(wr_ready), 0);
    chk("midrst_ram_addr", 32'(ram_addr), 0);
    chk("midrst_busy", 32'(busy), 0);
    @(negedge clk);
    wr_valid = 1'b0;
    rst_n = 1'b1;
    #1 chk("midrst_cmd_ready", 32'(cmd_ready), 1);
    ref_mem[4] = wbuf[0];
    ref_mem[5] = wbuf[1];
    chk("midrst_word6_kept", 32'(mem[6]), 32'(ref_mem[6]));
    read_burst(4, 4, 0);

    // Command held valid across a whole write burst.
    for (int i = 0; i < DEPTH; i++) wbuf[i] = 8'($urandom);
    send_cmd(1'b1, 5, 2);
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 3'd5;
    cmd_len   = 3'd2;
    write_body(5, 2, -1, 0);
    @(negedge clk);
    cmd_valid = 1'b0;
    read_body(5, 2, 0);

    // Randomized bursts.
    for (int n = 0; n < 16; n++) begin
      int a, l, sa;
      a  = $urandom_range(0, 7);
      l  = $urandom_range(0, 7);
      sa = $urandom_range(0, 9);
      for (int i = 0; i < DEPTH; i++) wbuf[i] = 8'($urandom);
      write_burst(a, l, sa, $urandom_range(1, 3));
      read_burst($urandom_range(0, 7), $urandom_range(0, 7), 2);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ram8_master.md
RAM8_MASTER -- requirements
Module: ram8_master

Interface
REQ-001 Parameters SHALL be: DATA_W, default 8, word width; ADDR_W, default 3, RAM address width (8 words).
REQ-002 The design SHALL use one clock and an asynchronous, active-low reset, with ports as follows.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 cmd_valid  in  1  command offered.
REQ-006 cmd_ready  out  1  command accepted when both high.
REQ-007 cmd_write  in  1  1 = burst write, 0 = burst read.
REQ-008 cmd_addr  in  ADDR_W  start address.
REQ-009 cmd_len  in  ADDR_W  word count minus 1 (0..7 -> 1..8 words).
REQ-010 wr_valid / wr_ready / wr_data  in / out / DATA_W  write-data stream.
REQ-011 rd_valid / rd_ready / rd_data  out / in / DATA_W  read-data stream.
REQ-012 ram_addr / ram_in / ram_load  out / out / 1  RAM port: address, write data, write enable.
REQ-013 ram_out  in  DATA_W  RAM combinational read data for ram_addr.
REQ-014 busy  out  1  high in any state other than IDLE.
REQ-015 done  out  1  one-cycle pulse at burst completion.

Function
REQ-016 The FSM SHALL have states IDLE, WRITE, READ, DONE.
REQ-017 IDLE: cmd_ready=1; on cmd_valid&&cmd_ready the block SHALL latch cur_addr=cmd_addr and remaining=cmd_len, then go to WRITE (cmd_write=1) or READ (cmd_write=0) next cycle.
REQ-018 cmd_ready SHALL be 0 in WRITE, READ and DONE; commands offered there are held off, not dropped.
REQ-019 WRITE: wr_ready=1, ram_addr=cur_addr, ram_in=wr_data, ram_load=wr_valid (combinational).
REQ-020 WRITE: each beat with wr_valid&&wr_ready writes the RAM on that edge, then cur_addr increments modulo 2^ADDR_W (7 wraps to 0).
REQ-021 WRITE: on the beat with remaining=0, go to DONE; otherwise decrement remaining.
REQ-022 WRITE: wr_valid low SHALL stall without writing or advancing.
REQ-023 ram_load SHALL be 0 in every state except WRITE; wr_ready SHALL be 0 outside WRITE.
REQ-024 READ: ram_addr=cur_addr; a one-entry output register holds rd_data/rd_valid.
REQ-025 READ fetch: when words remain unfetched and (rd_valid=0 or rd_ready=1), the block SHALL capture rd_data<=ram_out, set rd_valid=1 and advance cur_addr with wrap.
REQ-026 READ throughput and latency: one word per cycle under continuous rd_ready; first rd_valid one cycle after entering READ (two cycles after command acceptance).
REQ-027 rd_data SHALL be stable while rd_valid=1 and rd_ready=0.
REQ-028 READ: after the last word is consumed (rd_valid&&rd_ready with no fetch pending), rd_valid SHALL clear and the FSM SHALL go to DONE.
REQ-029 DONE: done=1 for exactly one cycle, then IDLE; a new command is accepted no earlier than the cycle after DONE.
REQ-030 The address sequence SHALL be (cmd_addr+i) mod 8, i=0..cmd_len; a burst of 8 words touches every address exactly once.

Reset
REQ-031 Asserting rst_n=0 SHALL immediately force state=IDLE, cur_addr=0, remaining=0, rd_valid=0, rd_data=0, done=0, busy=0, and make ram_load=0, wr_ready=0 and ram_addr=0 without waiting for a clock edge.
REQ-032 After reset, cmd_ready=1.
REQ-033 Reset mid-burst SHALL abandon the burst: no further RAM writes and no further rd_valid; RAM words already written are retained.
REQ-034 Deassertion of rst_n is assumed synchronous to clk.

Verification
REQ-035 Write-then-read: write addr=2 len=3, data 0x11,0x22,0x33,0x44 -> RAM[2..5] written; read addr=2 len=3 -> rd_data 0x11,0x22,0x33,0x44, done pulses once per burst.
REQ-036 Wrap: write addr=6 len=3, data A0..A3 -> ram_addr sequence 6,7,0,1; readback from addr=6 matches.
REQ-037 Backpressure: read len=7 with rd_ready toggling 1,0,0,1 -> all 8 words delivered in order, no duplicates or losses; rd_data stable while stalled.
REQ-038 Write stall: wr_valid low for 3 cycles mid-burst -> ram_load=0 during the gap, cur_addr unchanged, burst completes correctly.
REQ-039 Reset mid-burst: rst_n low after 2 of 5 write beats -> ram_load drops immediately; only 2 words are written; cmd_ready=1 after release.
REQ-040 Command during busy: cmd_valid held high throughout a burst -> second command accepted only in the IDLE cycle after done.
